// File: rtl/golden_nonce_uart_tx.sv
// Queues golden nonces in a small FIFO and sends each one as a 5-byte 8N1 UART frame.
// The frame is the marker byte 0x47 followed by the nonce, most significant byte first.
module golden_nonce_uart_tx #(
    parameter int BAUD_DIV  = 434,
    parameter int FIFO_LOG2 = 3
) (
    input  logic                 hash_clk,
    input  logic                 reset,
    input  logic                 nonce_valid,
    input  logic [31:0]          nonce_in,
    output logic                 uart_tx,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_LOG2:0]   fifo_count
);

    localparam int                 DEPTH     = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_CNT = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]        BAUD_LOAD = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_reg;
    logic [31:0]          fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_reg;
    logic [FIFO_LOG2-1:0] rd_ptr_reg;
    logic [FIFO_LOG2:0]   count_reg;
    logic                 overflow_reg;
    logic [39:0]          frame_reg;
    logic [15:0]          baud_cnt_reg;
    logic [2:0]           byte_idx_reg;
    logic [2:0]           bit_idx_reg;
    logic                 tx_reg;

    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       push;
    logic       baud_tick;
    logic [7:0] cur_byte;

    assign fifo_full  = (count_reg == DEPTH_CNT);
    assign fifo_empty = (count_reg == '0);
    assign pop        = (state_reg == IDLE) && !fifo_empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
    assign push       = nonce_valid && !reset && (!fifo_full || pop);
    assign baud_tick  = (baud_cnt_reg == '0);
    assign cur_byte   = frame_reg[39:32];

    always_ff @(posedge hash_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= nonce_in;
        end
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (nonce_valid && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Each state lasts a whole number of baud periods; the counter reloads on every bit boundary.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            frame_reg    <= '0;
            baud_cnt_reg <= '0;
            byte_idx_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        frame_reg    <= {8'h47, fifo_mem[rd_ptr_reg]};
                        byte_idx_reg <= '0;
                        bit_idx_reg  <= '0;
                        baud_cnt_reg <= BAUD_LOAD;
                        tx_reg       <= 1'b0;
                        state_reg    <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= BAUD_LOAD;
                        bit_idx_reg  <= '0;
                        tx_reg       <= cur_byte[0];
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= BAUD_LOAD;
                        if (bit_idx_reg == 3'd7) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx_reg      <= cur_byte[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 1'b1;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        baud_cnt_reg <= BAUD_LOAD;
                        if (byte_idx_reg < 3'd4) begin
                            byte_idx_reg <= byte_idx_reg + 1'b1;
                            frame_reg    <= {frame_reg[31:0], 8'h00};
                            tx_reg       <= 1'b0;
                            state_reg    <= START;
                        end else begin
                            tx_reg    <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign uart_tx    = tx_reg;
    assign overflow   = overflow_reg;
    assign fifo_count = count_reg;
    assign busy       = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: per-cycle comparison against a timing model of the frame,
// plus an independent mid-bit UART receiver that decodes the line.
module tb_golden_nonce_uart_tx;

    localparam int B     = 4;
    localparam int FL    = 3;
    localparam int DEPTH = 1 << FL;

    logic        hash_clk = 1'b0;
    logic        reset = 1'b0;
    logic        nonce_valid = 1'b0;
    logic [31:0] nonce_in = '0;
    logic        uart_tx;
    logic        busy;
    logic        overflow;
    logic [FL:0] fifo_count;

    golden_nonce_uart_tx #(.BAUD_DIV(B), .FIFO_LOG2(FL)) dut (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .nonce_valid (nonce_valid),
        .nonce_in    (nonce_in),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    always #5 hash_clk = ~hash_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending nonces and the edge at which the current frame began.
    logic [31:0] m_q[$];
    logic [31:0] m_sent[$];
    logic [31:0] m_cur = '0;
    logic        m_ovf = 1'b0;
    bit          p_valid = 1'b0;
    int          cyc = 0;
    int          free_at = 0;
    int          pstart = 0;

    // Independent line receiver
    logic [7:0] rx_q[$];
    int         rst_events = 0;
    int         rx_frame_err = 0;

    typedef struct {
        logic [31:0] nonce;
        logic [39:0] frame;
    } vec_t;
    vec_t vecs[5];

    always @(posedge reset) rst_events <= rst_events + 1;

    initial begin
        int          ev;
        logic [9:0]  bits;
        forever begin
            @(negedge hash_clk);
            if (!reset && uart_tx === 1'b0) begin
                ev = rst_events;
                for (int k = 0; k < 10; k++) begin
                    repeat ((k == 0) ? B / 2 : B) @(negedge hash_clk);
                    bits[k] = uart_tx;
                end
                if (ev == rst_events && !reset) begin
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) rx_frame_err++;
                    else rx_q.push_back(bits[8:1]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_line();
        int          off;
        int          byi;
        int          bi;
        logic [39:0] fr;
        logic [7:0]  by;
        if (!p_valid || (cyc - pstart) >= 50 * B) return 1'b1;
        off = cyc - pstart;
        byi = off / (10 * B);
        bi  = (off % (10 * B)) / B;
        fr  = {8'h47, m_cur};
        by  = fr[39 - 8 * byi -: 8];
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return by[bi - 1];
    endfunction

    function automatic logic exp_busy();
        return (p_valid && cyc < free_at - 1) || (m_q.size() != 0);
    endfunction

    task automatic model_edge(input logic v, input logic [31:0] d);
        bit do_pop;
        bit do_push;
        cyc++;
        do_pop  = (m_q.size() != 0) && (cyc >= free_at);
        do_push = v && ((m_q.size() < DEPTH) || do_pop);
        if (v && !do_push) m_ovf = 1'b1;
        if (do_pop) begin
            m_cur   = m_q.pop_front();
            m_sent.push_back(m_cur);
            pstart  = cyc;
            p_valid = 1'b1;
            free_at = cyc + 50 * B + 1;
            $display("tx frame: nonce=%h start_cycle=%0d queued=%0d", m_cur, cyc, m_q.size());
        end
        if (do_push) m_q.push_back(d);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        p_valid = 1'b0;
        free_at = 0;
    endtask

    task automatic tick(input logic v, input logic [31:0] d);
        nonce_valid = v;
        nonce_in    = d;
        model_edge(v, d);
        @(posedge hash_clk);
        @(negedge hash_clk);
        nonce_valid = 1'b0;
        check("uart_tx", uart_tx, exp_line());
        check("fifo_count", fifo_count, m_q.size());
        check("overflow", overflow, m_ovf);
        check("busy", busy, exp_busy());
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((busy || m_q.size() != 0) && n < limit) begin
            tick(1'b0, '0);
            n++;
        end
        check("drain_timeout_busy", busy, 1'b0);
    endtask

    task automatic run_until_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            tick(1'b0, '0);
            n++;
        end
    endtask

    task automatic check_rx(input logic [39:0] frame, input string name);
        for (int i = 0; i < 5; i++) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: no byte received, expected %h", name, frame[39 - 8 * i -: 8]);
            end else begin
                check(name, rx_q.pop_front(), frame[39 - 8 * i -: 8]);
            end
        end
    endtask

    initial begin
        int          n;
        int          base;
        logic [31:0] v;
        logic [31:0] wrap_vals[$];

        vecs[0] = '{32'hFFFFFFFF, 40'h47FFFFFFFF};
        vecs[1] = '{32'h00000000, 40'h4700000000};
        vecs[2] = '{32'hA5C30F1E, 40'h47A5C30F1E};
        vecs[3] = '{32'h80000001, 40'h4780000001};
        vecs[4] = '{32'hDEADBEEF, 40'h47DEADBEEF};

        #1 reset = 1'b1;
        repeat (3) @(negedge hash_clk);
        check("reset_uart_tx", uart_tx, 1'b1);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (2) tick(1'b0, '0);

        // Single nonce: one-cycle latency to the start bit, 200-cycle frame
        tick(1'b1, 32'h12345678);
        check("lat_count_after_push", fifo_count, 1);
        check("lat_line_idle", uart_tx, 1'b1);
        tick(1'b0, '0);
        check("lat_start_bit", uart_tx, 1'b0);
        check("lat_count_after_pop", fifo_count, 0);
        run_until_idle(n);
        check("frame_len", n, 200);
        tick(1'b0, '0);
        check_rx(40'h4712345678, "rx_12345678");

        for (int i = 0; i < 5; i++) begin
            tick(1'b1, vecs[i].nonce);
            drain(1000);
            check_rx(vecs[i].frame, "rx_vector");
        end

        // Back-to-back strobes: two frames separated by one idle cycle
        tick(1'b1, 32'hFFFFFFFF);
        tick(1'b1, 32'h00000000);
        run_until_idle(n);
        check("two_frame_len", n, 401);
        check_rx(40'h47FFFFFFFF, "rx_pair_first");
        check_rx(40'h4700000000, "rx_pair_second");

        // Burst of 10: one in flight, 8 queued, 1 dropped
        for (int k = 0; k < 10; k++) tick(1'b1, 32'(k));
        check("burst_count", fifo_count, DEPTH);
        check("burst_overflow", overflow, 1'b1);
        drain(5000);
        check("burst_overflow_sticky", overflow, 1'b1);
        for (int k = 0; k < 9; k++) check_rx({8'h47, 32'(k)}, "rx_burst");

        // Asynchronous reset in the data bits of byte 3
        tick(1'b1, 32'hCAFE00BE);
        for (int k = 0; k < 4; k++) tick(1'b1, 32'h1000 + 32'(k));
        n = 0;
        while (cyc < pstart + 30 * B + B + 3 && n < 1000) begin
            tick(1'b0, '0);
            n++;
        end
        check("pre_reset_line_low", uart_tx, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("async_reset_uart_tx", uart_tx, 1'b1);
        check("async_reset_count", fifo_count, 0);
        check("async_reset_overflow", overflow, 1'b0);
        check("async_reset_busy", busy, 1'b0);
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge hash_clk);
            nonce_valid = 1'b1;
            nonce_in    = $urandom;
        end
        @(negedge hash_clk);
        check("reset_ignores_valid", fifo_count, 0);
        nonce_valid = 1'b0;
        reset = 1'b0;
        repeat (100) tick(1'b0, '0);
        check("post_reset_quiet", busy, 1'b0);
        rx_q.delete();

        // Push on the same edge as a pop while full
        for (int k = 0; k < 9; k++) tick(1'b1, 32'd100 + 32'(k));
        check("full_count", fifo_count, DEPTH);
        check("full_no_overflow", overflow, 1'b0);
        n = 0;
        while (cyc + 1 < free_at && n < 1000) begin
            tick(1'b0, '0);
            n++;
        end
        tick(1'b1, 32'h5A5A5A5A);
        check("pop_push_full_count", fifo_count, DEPTH);
        check("pop_push_full_overflow", overflow, 1'b0);
        drain(5000);
        for (int k = 0; k < 9; k++) check_rx({8'h47, 32'd100 + 32'(k)}, "rx_full");
        check_rx(40'h475A5A5A5A, "rx_full_last");

        // Pointer wrap: 3*depth nonces, one at a time
        for (int k = 0; k < 3 * DEPTH; k++) begin
            v = $urandom;
            wrap_vals.push_back(v);
            tick(1'b1, v);
            drain(1000);
        end
        check("wrap_overflow", overflow, 1'b0);
        foreach (wrap_vals[k]) check_rx({8'h47, wrap_vals[k]}, "rx_wrap");

        // Random strobes at a sparse and a dense rate
        base = m_sent.size();
        for (int k = 0; k < 1500; k++) begin
            v = $urandom;
            tick(($urandom_range(0, 149) == 0), v);
        end
        for (int k = 0; k < 1500; k++) begin
            v = $urandom;
            tick(($urandom_range(0, 14) == 0), v);
        end
        drain(5000);
        tick(1'b0, '0);
        for (int k = base; k < m_sent.size(); k++) check_rx({8'h47, m_sent[k]}, "rx_random");

        check("rx_framing_errors", rx_frame_err, 0);
        check("rx_leftover_bytes", rx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
